// File: rtl/avalon_master_ctrl_if.sv
// Bundle of the host command/response, burst write-data stream and Avalon-MM
// initiator signals of avalon_master_ctrl. The block uses the master modport;
// the environment (host + Avalon slave) uses the slave modport.
interface avalon_master_ctrl_if;
  // host command / completion
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_burst;
  logic [10:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  // burst beat stream
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] wd_data;
  // Avalon-MM
  logic [10:0] address;
  logic        read;
  logic        write;
  logic        beginbursttransfer;
  logic [9:0]  burstcount;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        writeresponsevalid;
  logic [1:0]  response;

  modport master (
    input  cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_code,
    input  wd_valid, wd_data,
    output wd_ready,
    output address, read, write, beginbursttransfer, burstcount, writedata,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_code,
    output wd_valid, wd_data,
    input  wd_ready,
    input  address, read, write, beginbursttransfer, burstcount, writedata,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/avalon_master_ctrl.sv
// Avalon-MM initiator: single read, single write and burst write, one command
// at a time, one completion per command.
// Optional feature macro: AVM_TIMEOUT_EN adds a response/stall watchdog that
// completes a stuck command with rsp_code 2'b10 after TIMEOUT_CYC cycles.
// All Avalon outputs come straight from flops. Burst beats are loaded into the
// writedata register from the stream; the producer holds the beat until
// wd_ready, which pulses in the cycle the slave takes it, so one idle cycle
// follows each transferred beat.
module avalon_master_ctrl #(
  parameter logic [10:0] MAXADDR     = 11'h62C,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 n_rst,
  avalon_master_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_RESP, BW_FIRST, BW_BEAT, BW_RESP, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        bbt_q, bbt_d;
  logic [9:0]  burstcount_q, burstcount_d;
  logic [9:0]  beats_q, beats_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  code_q, code_d;

  logic [11:0] burst_end;
  logic        legal;

  // burst end computed 12 bits wide so a large length cannot wrap past MAXADDR
  assign burst_end = {1'b0, bus.cmd_addr} + {2'b00, bus.cmd_len};
  assign legal = bus.cmd_burst
               ? (bus.cmd_write && (bus.cmd_addr != 11'd0) && (bus.cmd_len != 10'd0) &&
                  (burst_end < {1'b0, MAXADDR}))
               : ((bus.cmd_addr != 11'd0) && (bus.cmd_addr < MAXADDR));

`ifdef AVM_TIMEOUT_EN
  logic [8:0] tmo_q, tmo_d;
  logic       stalled;
  logic       tmo_hit;

  // a cycle counts towards the watchdog only when the slave makes no progress
  always_comb begin
    stalled = 1'b0;
    unique case (state_q)
      RD_REQ, WR_REQ:   stalled = bus.waitrequest;
      BW_BEAT:          stalled = write_q && bus.waitrequest;
      RD_WAIT:          stalled = !bus.readdatavalid;
      WR_RESP, BW_RESP: stalled = !bus.writeresponsevalid;
      default:          stalled = 1'b0;
    endcase
    tmo_hit = stalled && (tmo_q == 9'(TIMEOUT_CYC - 1));
    tmo_d   = stalled ? tmo_q + 9'd1 : 9'd0;
  end

  // watchdog counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tmo_q <= 9'd0;
    else        tmo_q <= tmo_d;
  end
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    bbt_d        = 1'b0;
    burstcount_d = burstcount_q;
    beats_d      = beats_q;
    writedata_d  = writedata_q;
    rdata_d      = rdata_q;
    code_d       = code_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          rdata_d = 32'd0;
          code_d  = 2'b00;
          if (!legal) begin
            code_d  = 2'b11;
            state_d = DONE;
          end else if (bus.cmd_burst) begin
            address_d    = bus.cmd_addr;
            burstcount_d = bus.cmd_len;
            beats_d      = bus.cmd_len;
            state_d      = BW_FIRST;
          end else if (bus.cmd_write) begin
            address_d   = bus.cmd_addr;
            writedata_d = bus.cmd_wdata;
            write_d     = 1'b1;
            state_d     = WR_REQ;
          end else begin
            address_d = bus.cmd_addr;
            read_d    = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!bus.waitrequest) begin
          read_d    = 1'b0;
          address_d = 11'd0;
          if (bus.readdatavalid) begin
            rdata_d = bus.readdata;
            code_d  = bus.response;
            state_d = DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus.readdatavalid) begin
          rdata_d = bus.readdata;
          code_d  = bus.response;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        if (!bus.waitrequest) begin
          write_d     = 1'b0;
          address_d   = 11'd0;
          writedata_d = 32'd0;
          state_d     = WR_RESP;
        end
      end
      WR_RESP, BW_RESP: begin
        if (bus.writeresponsevalid) begin
          code_d  = bus.response;
          state_d = DONE;
        end
      end
      BW_FIRST: begin
        if (bus.wd_valid) begin
          write_d     = 1'b1;
          bbt_d       = 1'b1;
          writedata_d = bus.wd_data;
          state_d     = BW_BEAT;
        end
      end
      BW_BEAT: begin
        if (write_q) begin
          if (!bus.waitrequest) begin
            write_d     = 1'b0;
            writedata_d = 32'd0;
            beats_d     = beats_q - 10'd1;
            if (beats_q == 10'd1) begin
              address_d    = 11'd0;
              burstcount_d = 10'd0;
              state_d      = BW_RESP;
            end
          end
        end else if (bus.wd_valid) begin
          write_d     = 1'b1;
          writedata_d = bus.wd_data;
        end
      end
      DONE: begin
        rdata_d = 32'd0;
        code_d  = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AVM_TIMEOUT_EN
    if (tmo_hit) begin
      read_d       = 1'b0;
      write_d      = 1'b0;
      address_d    = 11'd0;
      burstcount_d = 10'd0;
      writedata_d  = 32'd0;
      rdata_d      = 32'd0;
      code_d       = 2'b10;
      state_d      = DONE;
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      address_q    <= 11'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      bbt_q        <= 1'b0;
      burstcount_q <= 10'd0;
      beats_q      <= 10'd0;
      writedata_q  <= 32'd0;
      rdata_q      <= 32'd0;
      code_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      bbt_q        <= bbt_d;
      burstcount_q <= burstcount_d;
      beats_q      <= beats_d;
      writedata_q  <= writedata_d;
      rdata_q      <= rdata_d;
      code_q       <= code_d;
    end
  end

  assign bus.cmd_ready          = (state_q == IDLE);
  assign bus.rsp_valid          = (state_q == DONE);
  assign bus.rsp_data           = rdata_q;
  assign bus.rsp_code           = code_q;
  assign bus.wd_ready           = (state_q == BW_BEAT) && write_q && !bus.waitrequest;
  assign bus.address            = address_q;
  assign bus.read               = read_q;
  assign bus.write              = write_q;
  assign bus.beginbursttransfer = bbt_q;
  assign bus.burstcount         = burstcount_q;
  assign bus.writedata          = writedata_q;

endmodule
